// File: rtl/dspl_rx.sv
// -----------------------------------------------------------------------------
// dspl_rx
// Receiver / decoder for the multiplexed 8-digit seven-segment bus.
//
// Follows the active-low anode scan on `an`, waits until a digit select has
// been stable for SETTLE cycles, samples the active-low cathodes on `dec_cat`,
// decodes the pattern back to a hex nibble and stores it in a shadow frame.
// Once all eight digits have been captured, the shadow frame is copied to the
// outputs in one step and `frame_valid` pulses for one cycle.
//
// Optional build macro:
//   DSPL_RX_SYNC_EN  - when defined, `an` and `dec_cat` go through a 2-flop
//                      synchronizer (reset to 8'hFF) before the FSM. This adds
//                      two cycles to every latency. Leave it undefined for the
//                      same-clock on-chip bus.
//
// Handshake: there is no back-pressure. `frame_valid` is a single-cycle
// strobe. `digits`, `blank`, `dp` and `seg_err` change only in the cycle in
// which it is high, and they hold their values until the next strobe.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   an[7:0]      anode select, active-low, one-hot-low when valid
//   dec_cat[7:0] cathodes, active-low: [7:1] = segments a..g, [0] = dp
//   digits[31:0] decoded frame, digit i in digits[4i+3:4i]
//   blank[7:0]   digit i had all segments off
//   dp[7:0]      digit i had its decimal point lit
//   frame_valid  one-cycle pulse when the frame outputs update
//   seg_err[7:0] digit i showed an undecodable, non-blank pattern
//   state_dbg    current FSM state (0 idle, 1 settle, 2 capture, 3 wait)
// -----------------------------------------------------------------------------
module dspl_rx #(
   parameter int unsigned SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  an,
   input  logic [7:0]  dec_cat,
   output logic [31:0] digits,
   output logic [7:0]  blank,
   output logic [7:0]  dp,
   output logic        frame_valid,
   output logic [7:0]  seg_err,
   output logic [1:0]  state_dbg
);

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_WAIT    = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   logic [7:0] an_s;
   logic [7:0] cat_s;

`ifdef DSPL_RX_SYNC_EN
   logic [7:0] an_m;
   logic [7:0] cat_m;

   // Reset to all-ones: that is "no digit selected, all segments off", so
   // the FSM sees an idle bus while the synchronizer fills.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_m  <= 8'hFF;
         cat_m <= 8'hFF;
         an_s  <= 8'hFF;
         cat_s <= 8'hFF;
      end else begin
         an_m  <= an;
         cat_m <= dec_cat;
         an_s  <= an_m;
         cat_s <= cat_m;
      end
   end
`else
   assign an_s  = an;
   assign cat_s = dec_cat;
`endif

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   // Returns {err, blank, value[3:0]} for an active-high abcdefg pattern.
   function automatic logic [5:0] seg_decode(input logic [6:0] p);
      logic [5:0] r;
      case (p)
         7'h7E:   r = 6'h00;
         7'h30:   r = 6'h01;
         7'h6D:   r = 6'h02;
         7'h79:   r = 6'h03;
         7'h33:   r = 6'h04;
         7'h5B:   r = 6'h05;
         7'h5F:   r = 6'h06;
         7'h70:   r = 6'h07;
         7'h7F:   r = 6'h08;
         7'h7B:   r = 6'h09;
         7'h77:   r = 6'h0A;
         7'h1F:   r = 6'h0B;
         7'h4E:   r = 6'h0C;
         7'h3D:   r = 6'h0D;
         7'h4F:   r = 6'h0E;
         7'h47:   r = 6'h0F;
         7'h00:   r = 6'b01_0000;
         default: r = 6'b10_0000;
      endcase
      return r;
   endfunction

   // Position of the low bit in a one-hot-low anode word.
   function automatic logic [2:0] low_idx(input logic [7:0] a);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!a[i]) r = 3'(i);
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State and storage
   // ---------------------------------------------------------------------------
   state_t     state;
   logic [7:0] cnt;
   logic [7:0] an_q;        // anode word being tracked
   logic [6:0] pat_q;       // sampled segments, active-high
   logic       dp_q;        // sampled decimal point, active-high
   logic [7:0] seen;
   logic [31:0] sh_digits;
   logic [7:0]  sh_blank;
   logic [7:0]  sh_dp;
   logic [7:0]  sh_err;

   logic [7:0] an_inv;
   logic       an_ok;
   logic [7:0] cnt_inc;
   logic [2:0] idx;
   logic [5:0] dec;

   logic [31:0] nx_digits;
   logic [7:0]  nx_blank;
   logic [7:0]  nx_dp;
   logic [7:0]  nx_err;
   logic [7:0]  nx_seen;

   assign state_dbg = state;

   // Valid anode word: exactly one bit low.
   assign an_inv  = ~an_s;
   assign an_ok   = (an_inv != 8'd0) && ((an_inv & (an_inv - 8'd1)) == 8'd0);

   // Saturating stable counter.
   assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   assign idx = low_idx(an_q);
   assign dec = seg_decode(pat_q);

   // Shadow frame as it would look after writing the sampled digit. Used
   // both for the normal slot write and for the publish that completes a
   // frame, so the last digit lands in the outputs in the same step.
   always_comb begin
      nx_digits = sh_digits;
      nx_blank  = sh_blank;
      nx_dp     = sh_dp;
      nx_err    = sh_err;
      nx_seen   = seen | (8'd1 << idx);
      nx_digits[{idx, 2'b00} +: 4] = dec[3:0];
      nx_blank[idx]                = dec[4];
      nx_dp[idx]                   = dp_q;
      nx_err[idx]                  = dec[5];
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= 8'd0;
         an_q        <= 8'hFF;
         pat_q       <= 7'd0;
         dp_q        <= 1'b0;
         seen        <= 8'd0;
         sh_digits   <= 32'd0;
         sh_blank    <= 8'hFF;
         sh_dp       <= 8'd0;
         sh_err      <= 8'd0;
         digits      <= 32'd0;
         blank       <= 8'hFF;
         dp          <= 8'd0;
         seg_err     <= 8'd0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (an_ok) begin
                  an_q <= an_s;
                  cnt  <= 8'd1;
                  // With SETTLE of 1 the first valid cycle is already enough.
                  if (SETTLE_C <= 8'd1) begin
                     pat_q <= ~cat_s[7:1];
                     dp_q  <= ~cat_s[0];
                     state <= ST_CAPTURE;
                  end else begin
                     state <= ST_SETTLE;
                  end
               end
            end

            ST_SETTLE: begin
               if (an_s == an_q) begin
                  cnt <= cnt_inc;
                  // Cathodes are sampled on the edge the count is reached;
                  // decoding happens in CAPTURE so the scan may already move.
                  if (cnt_inc >= SETTLE_C) begin
                     pat_q <= ~cat_s[7:1];
                     dp_q  <= ~cat_s[0];
                     state <= ST_CAPTURE;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_CAPTURE: begin
               if (nx_seen == 8'hFF) begin
                  digits      <= nx_digits;
                  blank       <= nx_blank;
                  dp          <= nx_dp;
                  seg_err     <= nx_err;
                  frame_valid <= 1'b1;
                  seen        <= 8'd0;
                  sh_digits   <= nx_digits;
                  sh_blank    <= nx_blank;
                  sh_dp       <= nx_dp;
                  sh_err      <= 8'd0;
               end else begin
                  seen        <= nx_seen;
                  sh_digits   <= nx_digits;
                  sh_blank    <= nx_blank;
                  sh_dp       <= nx_dp;
                  sh_err      <= nx_err;
               end
               state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (an_s != an_q) state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dspl_rx.sv
// -----------------------------------------------------------------------------
// tb_dspl_rx
// Self-checking bench for dspl_rx (default build, SETTLE = 4).
// The bench drives "segments": an anode word and a cathode pattern held for a
// number of cycles. A frame-level model predicts which segments are captured
// (valid anode held for at least SETTLE+1 cycles) and what each completed frame
// must contain; completed frames go into an expected queue that a per-cycle
// compare process drains on every frame_valid pulse.
// -----------------------------------------------------------------------------
module tb_dspl_rx;

   localparam int SETTLE = 4;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  an = 8'hFF;
   logic [7:0]  dec_cat = 8'hFF;
   logic [31:0] digits;
   logic [7:0]  blank;
   logic [7:0]  dp;
   logic        frame_valid;
   logic [7:0]  seg_err;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   dspl_rx #(.SETTLE(SETTLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .dec_cat     (dec_cat),
      .digits      (digits),
      .blank       (blank),
      .dp          (dp),
      .frame_valid (frame_valid),
      .seg_err     (seg_err),
      .state_dbg   (state_dbg)
   );

   // ---------------------------------------------------------------------------
   // Model and scoreboard
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] d;
      logic [7:0]  b;
      logic [7:0]  p;
      logic [7:0]  e;
   } frame_t;

   localparam frame_t RESET_FRAME = '{d: 32'h0, b: 8'hFF, p: 8'h0, e: 8'h0};

   logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   frame_t     exp_q[$];
   frame_t     pub = RESET_FRAME;   // what the outputs must currently hold
   frame_t     sh  = RESET_FRAME;   // model shadow frame
   logic [7:0] seen_m = 8'h0;
   logic [7:0] last_an = 8'h00;
   int         n_total = 0;
   int         n_bad = 0;
   int         fv_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] cat_of(input int v, input logic dpl);
      logic [6:0] p;
      p = seg_tab[v];
      return {~p, ~dpl};
   endfunction

   // Model capture of one digit; returns 1 when it completes a frame.
   function automatic bit model_capture(input int i, input logic [7:0] cat);
      logic [6:0] p;
      logic [3:0] v;
      logic       bl, er;
      bit         done;
      p  = ~cat[7:1];
      v  = 4'd0;
      bl = (p == 7'h00);
      er = !bl;
      for (int k = 0; k < 16; k++) begin
         if (seg_tab[k] == p) begin
            v  = 4'(k);
            er = 1'b0;
         end
      end
      sh.d[4*i +: 4] = v;
      sh.b[i] = bl;
      sh.p[i] = ~cat[0];
      sh.e[i] = er;
      seen_m[i] = 1'b1;
      done = 1'b0;
      if (seen_m == 8'hFF) begin
         exp_q.push_back(sh);
         seen_m = 8'h0;
         sh.e   = 8'h0;
         done   = 1'b1;
      end
      return done;
   endfunction

   // ---------------------------------------------------------------------------
   // Compare process: every cycle, away from the rising edge
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst) begin
         check("reset_outputs", {digits, blank, dp, seg_err, frame_valid},
               {RESET_FRAME, 1'b0});
      end else if (frame_valid) begin
         fv_cnt++;
         if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_frame_valid: got 1 expected 0 (t=%0t)", $time);
         end else begin
            pub = exp_q.pop_front();
            check("frame", {digits, blank, dp, seg_err}, pub);
         end
      end else begin
         check("hold", {digits, blank, dp, seg_err}, pub);
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic seg(input logic [7:0] a, input logic [7:0] c, input int len);
      bit pushed;
      int i;
      pushed = 1'b0;
      if ($countones(~a) == 1 && len >= SETTLE + 1) begin
         i = 0;
         for (int k = 0; k < 8; k++) if (!a[k]) i = k;
         pushed = model_capture(i, c);
      end
      an      = a;
      dec_cat = c;
      repeat (len) @(posedge clk);
      #1;
      // A completing digit must have published within its own dwell.
      if (pushed) check("frame_latency_pending", 64'(exp_q.size()), 64'd0);
      last_an = a;
   endtask

   task automatic reset_dut();
      rst     = 1'b1;
      an      = 8'($urandom);
      dec_cat = 8'($urandom);
      sh      = RESET_FRAME;
      seen_m  = 8'h0;
      pub     = RESET_FRAME;
      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b0;
      last_an = 8'h00;
   endtask

   task automatic sweep(input logic [7:0] cats [8], input int short_i);
      for (int i = 0; i < 8; i++)
         seg(~(8'd1 << i), cats[i], (i == short_i) ? 4 : 8);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic [7:0] base [8];
   logic [7:0] cats [8];
   int         f0;

   initial begin
      for (int i = 0; i < 8; i++) base[i] = cat_of(i + 1, 1'b0);

      // Reset with random bus activity
      reset_dut();
      check("reset_digits", 64'(digits), 64'h0);
      check("reset_blank", 64'(blank), 64'hFF);
      check("reset_fv", 64'(fv_cnt), 64'd0);

      // Full scan
      f0 = fv_cnt;
      sweep(base, -1);
      check("full_fv_count", 64'(fv_cnt - f0), 64'd1);
      check("full_digits", 64'(digits), 64'h87654321);
      check("full_flags", {blank, dp, seg_err}, 64'h0);

      // Short dwell on digit 3, then a full sweep
      f0 = fv_cnt;
      sweep(base, 3);
      check("short_fv_count", 64'(fv_cnt - f0), 64'd0);
      f0 = fv_cnt;
      sweep(base, -1);
      check("after_short_fv_count", 64'(fv_cnt - f0), 64'd1);

      // Blank digit 5 and dp on digit 0 showing 0
      reset_dut();
      cats = base;
      cats[5] = 8'hFE;
      cats[0] = 8'h02;
      sweep(cats, -1);
      check("bdp_digits", 64'(digits), 64'h87054320);
      check("bdp_blank", 64'(blank), 64'h20);
      check("bdp_dp", 64'(dp), 64'h21);

      // Undecodable pattern on digit 2, then a clean frame
      reset_dut();
      cats = base;
      cats[2] = {~7'h01, 1'b1};
      sweep(cats, -1);
      check("bad_seg_err", 64'(seg_err), 64'h04);
      check("bad_digits", 64'(digits), 64'h87654021);
      sweep(base, -1);
      check("clean_seg_err", 64'(seg_err), 64'h00);

      // Invalid anode words and blanking gaps
      reset_dut();
      f0 = fv_cnt;
      seg(8'hFC, base[0], 20);
      check("invalid_fv_count", 64'(fv_cnt - f0), 64'd0);
      for (int i = 0; i < 8; i++) begin
         seg(8'hFF, 8'($urandom), 2);
         seg(~(8'd1 << i), base[i], 8);
      end
      check("gaps_fv_count", 64'(fv_cnt - f0), 64'd1);
      check("gaps_digits", 64'(digits), 64'h87654321);

      // Partial frame discarded by reset
      reset_dut();
      for (int i = 4; i < 8; i++) seg(~(8'd1 << i), cat_of(15, 1'b1), 8);
      reset_dut();
      f0 = fv_cnt;
      sweep(base, -1);
      check("midreset_fv_count", 64'(fv_cnt - f0), 64'd1);
      check("midreset_digits", 64'(digits), 64'h87654321);
      check("midreset_dp", 64'(dp), 64'h0);

      // Randomized segments
      for (int n = 0; n < 400; n++) begin
         int         kind;
         int         d;
         int         b;
         logic [7:0] a;
         logic [7:0] c;
         logic [6:0] p;
         kind = $urandom_range(0, 99);
         if (kind < 1) begin
            reset_dut();
         end else if (kind < 22) begin
            // invalid anode word: all high or two bits low
            if ($urandom_range(0, 1) == 0) begin
               a = 8'hFF;
            end else begin
               d = $urandom_range(0, 7);
               b = (d + $urandom_range(1, 7)) % 8;
               a = ~((8'd1 << d) | (8'd1 << b));
            end
            seg(a, 8'($urandom), $urandom_range(1, 6));
         end else begin
            d = $urandom_range(0, 7);
            a = ~(8'd1 << d);
            if (a == last_an) a = ~(8'd1 << ((d + 1) % 8));
            case ($urandom_range(0, 9))
               7:       p = 7'h00;
               8, 9:    p = 7'($urandom);
               default: p = seg_tab[$urandom_range(0, 15)];
            endcase
            c = {~p, 1'($urandom)};
            if (kind < 35) seg(a, c, $urandom_range(1, 3));
            else           seg(a, c, $urandom_range(8, 12));
         end
      end

      seg(8'hFF, 8'hFF, 10);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Absolute time limit
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
